// File: rtl/masked_match_table.sv
// Masked (ternary) match table: each entry matches a key on the bits its mask cares about; lowest index wins.
// Optional per-entry 8-bit saturating hit counters are built when MASKED_MATCH_HIT_COUNT_EN is defined.
module masked_match_table #(
    parameter int                 WIDTH       = 3,
    parameter int                 ENTRIES     = 4,
    parameter int                 RES_W       = 3,
    parameter logic [RES_W-1:0]   DEFAULT_RES = 3'b010,
    localparam int                IDX_W       = $clog2(ENTRIES)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [WIDTH-1:0]      cfg_value,
    input  logic [WIDTH-1:0]      cfg_mask,
    input  logic [RES_W-1:0]      cfg_result,
    input  logic                  cfg_en,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
`ifdef MASKED_MATCH_HIT_COUNT_EN
    input  logic [IDX_W-1:0]      hit_cnt_rd_idx,
    output logic [7:0]            hit_cnt,
`endif
    output logic                  out_valid,
    output logic                  out_hit,
    output logic [IDX_W-1:0]      out_idx,
    output logic [RES_W-1:0]      out_result
);

    logic                 en     [ENTRIES];
    logic [WIDTH-1:0]     value  [ENTRIES];
    logic [WIDTH-1:0]     mask   [ENTRIES];
    logic [RES_W-1:0]     result [ENTRIES];

    logic                 match_hit;
    logic [IDX_W-1:0]     match_idx;
    logic [RES_W-1:0]     match_res;

    // Indices outside the table never equal any loop index, so such writes fall through untouched.
    always_ff @(posedge clock) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (reset) begin
                en[i]     <= 1'b0;
                value[i]  <= '0;
                mask[i]   <= '0;
                result[i] <= '0;
            end else if (cfg_we && cfg_idx == IDX_W'(i)) begin
                en[i]     <= cfg_en;
                value[i]  <= cfg_value;
                mask[i]   <= cfg_mask;
                result[i] <= cfg_result;
            end
        end
    end

    // Scan from the top down so the lowest-index match is the last one assigned.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        match_res = DEFAULT_RES;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (en[i] && (((in_data ^ value[i]) & mask[i]) == '0)) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
                match_res = result[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_hit    <= 1'b0;
            out_idx    <= '0;
            out_result <= DEFAULT_RES;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_hit    <= match_hit;
                out_idx    <= match_idx;
                out_result <= match_res;
            end
        end
    end

`ifdef MASKED_MATCH_HIT_COUNT_EN
    logic [7:0] cnt [ENTRIES];

    // Counting follows the registered response; a table write to the same entry takes precedence.
    always_ff @(posedge clock) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (reset) begin
                cnt[i] <= '0;
            end else if (cfg_we && cfg_idx == IDX_W'(i)) begin
                cnt[i] <= '0;
            end else if (out_valid && out_hit && out_idx == IDX_W'(i) && cnt[i] != 8'hFF) begin
                cnt[i] <= cnt[i] + 8'd1;
            end
        end
    end

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (hit_cnt_rd_idx == IDX_W'(i)) begin
                hit_cnt = cnt[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_masked_match_table.sv
// Randomized scoreboard bench for masked_match_table against a first-match reference model.
// Counter checks are compiled in when MASKED_MATCH_HIT_COUNT_EN is defined.
module tb_masked_match_table;

    localparam int          WIDTH   = 3;
    localparam int          ENTRIES = 4;
    localparam int          RES_W   = 3;
    localparam int          IDX_W   = 2;
    localparam logic [2:0]  DEF_RES = 3'b010;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             cfg_we = 1'b0;
    logic [IDX_W-1:0] cfg_idx = '0;
    logic [WIDTH-1:0] cfg_value = '0;
    logic [WIDTH-1:0] cfg_mask = '0;
    logic [RES_W-1:0] cfg_result = '0;
    logic             cfg_en = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_hit;
    logic [IDX_W-1:0] out_idx;
    logic [RES_W-1:0] out_result;
`ifdef MASKED_MATCH_HIT_COUNT_EN
    logic [IDX_W-1:0] hit_cnt_rd_idx = '0;
    logic [7:0]       hit_cnt;
`endif

    masked_match_table dut (
        .clock(clock), .reset(reset),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_value(cfg_value), .cfg_mask(cfg_mask),
        .cfg_result(cfg_result), .cfg_en(cfg_en),
        .in_valid(in_valid), .in_data(in_data),
`ifdef MASKED_MATCH_HIT_COUNT_EN
        .hit_cnt_rd_idx(hit_cnt_rd_idx), .hit_cnt(hit_cnt),
`endif
        .out_valid(out_valid), .out_hit(out_hit), .out_idx(out_idx), .out_result(out_result)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
        logic [2:0] res;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   started  = 1'b0;
    logic rst_seen = 1'b0;
    exp_t last_exp;

    // Reference table
    bit       m_en   [ENTRIES];
    bit [2:0] m_val  [ENTRIES];
    bit [2:0] m_mask [ENTRIES];
    bit [2:0] m_res  [ENTRIES];
    int       m_cnt  [ENTRIES];
    bit       pend_inc = 1'b0;
    int       pend_idx = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit entry_matches(input int i, input bit [2:0] key);
        if (!m_en[i]) return 1'b0;
        for (int b = 0; b < WIDTH; b++)
            if (m_mask[i][b] && (key[b] != m_val[i][b])) return 1'b0;
        return 1'b1;
    endfunction

    function automatic exp_t model_lookup(input bit [2:0] key);
        exp_t e;
        e.hit = 1'b0; e.idx = 2'd0; e.res = DEF_RES;
        for (int i = 0; i < ENTRIES; i++) begin
            if (entry_matches(i, key)) begin
                e.hit = 1'b1; e.idx = 2'(i); e.res = m_res[i];
                break;
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_en[i] = 0; m_val[i] = 0; m_mask[i] = 0; m_res[i] = 0; m_cnt[i] = 0;
        end
        pend_inc = 1'b0;
    endtask

    // One clock of stimulus; the model mirrors what each edge does to the table and counters.
    task automatic applyStimulus(input bit rst, input bit we, input bit [1:0] idx, input bit [2:0] val,
                                 input bit [2:0] msk, input bit [2:0] res, input bit en,
                                 input bit iv, input bit [2:0] data);
        exp_t e;
        reset = rst; cfg_we = we; cfg_idx = idx; cfg_value = val; cfg_mask = msk;
        cfg_result = res; cfg_en = en; in_valid = iv; in_data = data;
        if (rst) begin
            model_reset();
        end else begin
            if (pend_inc && m_cnt[pend_idx] < 255) m_cnt[pend_idx]++;
            pend_inc = 1'b0;
            if (iv) begin
                e = model_lookup(data);
                sb.push_back(e);
                if (e.hit) begin pend_inc = 1'b1; pend_idx = int'(e.idx); end
            end
            if (we) begin
                m_en[idx] = en; m_val[idx] = val; m_mask[idx] = msk; m_res[idx] = res;
                m_cnt[idx] = 0;
            end
        end
        @(posedge clock);
        #1;
        reset = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic lookup(input bit [2:0] data);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, data);
    endtask

    task automatic write_entry(input bit [1:0] idx, input bit [2:0] val, input bit [2:0] msk,
                               input bit [2:0] res, input bit en);
        applyStimulus(0, 1, idx, val, msk, res, en, 0, 0);
    endtask

`ifdef MASKED_MATCH_HIT_COUNT_EN
    task automatic check_counters();
        for (int i = 0; i < ENTRIES; i++) begin
            hit_cnt_rd_idx = 2'(i);
            #0.5;
            checkOutput("hit_cnt", 32'(hit_cnt), 32'(m_cnt[i]));
        end
    endtask
`endif

    always @(posedge clock) rst_seen <= reset;

    // Monitor: pops on every response, checks reset values and hold behaviour otherwise.
    always @(negedge clock) begin
        exp_t e;
        if (started) begin
            if (rst_seen) begin
                checkOutput("rst_valid", 32'(out_valid), 32'd0);
                checkOutput("rst_hit", 32'(out_hit), 32'd0);
                checkOutput("rst_idx", 32'(out_idx), 32'd0);
                checkOutput("rst_result", 32'(out_result), 32'(DEF_RES));
                last_exp = '{hit: 1'b0, idx: 2'd0, res: DEF_RES};
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_valid: got out_valid=1, expected no response at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    checkOutput("out_hit", 32'(out_hit), 32'(e.hit));
                    checkOutput("out_idx", 32'(out_idx), 32'(e.idx));
                    checkOutput("out_result", 32'(out_result), 32'(e.res));
                    last_exp = e;
                end
            end else begin
                checkOutput("hold_hit", 32'(out_hit), 32'(last_exp.hit));
                checkOutput("hold_idx", 32'(out_idx), 32'(last_exp.idx));
                checkOutput("hold_result", 32'(out_result), 32'(last_exp.res));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit [2:0] key;
        model_reset();
        @(posedge clock);
        #1;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        started = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Fresh table misses everything
        lookup(3'b101);
        idle(1);

        // Masked entry matches 10x
        write_entry(0, 3'b100, 3'b110, 3'd1, 1);
        lookup(3'b100);
        lookup(3'b101);
        lookup(3'b001);

        // Priority, then disable the winner
        write_entry(0, 3'b011, 3'b111, 3'd3, 1);
        write_entry(1, 3'b011, 3'b111, 3'd5, 1);
        lookup(3'b011);
        write_entry(0, 3'b011, 3'b111, 3'd3, 0);
        lookup(3'b011);

        // Same-cycle rewrite: lookup sees the old result
        write_entry(0, 3'b011, 3'b111, 3'd3, 1);
        applyStimulus(0, 1, 0, 3'b011, 3'b111, 3'd6, 1, 1, 3'b011);
        lookup(3'b011);

        // Reset with a lookup in the same edge drops it and clears the table
        lookup(3'b011);
        applyStimulus(1, 1, 2, 3'b011, 3'b000, 3'd7, 1, 1, 3'b011);
        lookup(3'b011);
        idle(2);

        // Enabled all-zero mask matches every key
        write_entry(3, 3'b101, 3'b000, 3'd7, 1);
        for (int k = 0; k < 8; k++) lookup(3'(k));

`ifdef MASKED_MATCH_HIT_COUNT_EN
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        write_entry(2, 3'b000, 3'b000, 3'd4, 1);
        for (int k = 0; k < 300; k++) lookup(3'($urandom_range(0, 7)));
        idle(2);
        hit_cnt_rd_idx = 2'd2;
        #0.5;
        checkOutput("hit_cnt_sat", 32'(hit_cnt), 32'd255);
        write_entry(2, 3'b000, 3'b000, 3'd4, 1);
        idle(1);
        hit_cnt_rd_idx = 2'd2;
        #0.5;
        checkOutput("hit_cnt_clr", 32'(hit_cnt), 32'd0);
`endif

        // Random traffic
        for (int k = 0; k < 500; k++) begin
            key = 3'($urandom_range(0, 7));
            applyStimulus(($urandom_range(0, 99) < 2),
                          ($urandom_range(0, 99) < 30),
                          2'($urandom_range(0, 3)),
                          3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)),
                          ($urandom_range(0, 99) < 75),
                          ($urandom_range(0, 99) < 70),
                          key);
`ifdef MASKED_MATCH_HIT_COUNT_EN
            if (k % 50 == 0) check_counters();
`endif
        end

        idle(3);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain: got %0d pending responses, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
